sr_layer_sequencer: RTL and testbench
=====================================

# sr_layer_sequencer

Central controller for the super-resolution CNN core. It loads each layer's weight/bias memory in turn through one shared weight-load port. It then sequences per-pixel inference through the layer chain: upsample, then the conv layers, one layer active at a time, using start/done handshakes and a per-layer watchdog. It sits between the frame-level pixel scheduler (upstream) and the `upsample_layer`/`conv_layer` instances (downstream).

## Interface
Parameters:
- `NUM_LAYERS`, 6: layers in chain; layer 0 = upsample, 1..NUM_LAYERS-1 = conv.
- `ADDR_WIDTH`, 18: weight address width.
- `LEN_W`, 11: width of one layer-length field.
- `LAYER_LEN`, {11'd246, 11'd738, 11'd738, 11'd738, 11'd981, 11'd336}: packed word count (weights plus biases) per layer. Layer i occupies `[i*LEN_W +: LEN_W]`. Every field must be ≥1.
- `WDOG_CYCLES`, 4096: maximum cycles allowed waiting for one layer_done.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `cfg_start`, in, 1: pulse; (re)load all weights.
- `wl_rd_en`, out, 1: read strobe to the shared weight loader.
- `wl_rd_addr`, out, ADDR_WIDTH: per-layer local read address.
- `wl_wr_en`, out, NUM_LAYERS: one-hot write enable to the layer register files. It is `wl_rd_en` delayed one cycle, steered to the selected layer.
- `wl_wr_addr`, out, ADDR_WIDTH: `wl_rd_addr` delayed one cycle.
- `weights_ready`, out, 1: all layers loaded and idle.
- `pix_valid`, in, 1: upstream requests one pixel inference.
- `pix_ready`, out, 1: request accepted when `pix_valid && pix_ready`.
- `layer_start`, out, NUM_LAYERS: one-hot single-cycle start.
- `layer_done`, in, NUM_LAYERS: per-layer completion pulses.
- `pix_done`, out, 1: single-cycle pulse; pixel finished successfully.
- `busy`, out, 1: high in LOAD or WAIT.
- `err_timeout`, out, 1: sticky watchdog flag.
- `err_clear`, in, 1: clears `err_timeout`.

## Operation
- States: IDLE, LOAD, READY, WAIT.
- IDLE: all outputs low. `cfg_start` → LOAD with layer=0, addr=0.
- LOAD:
  - `wl_rd_en` = 1 and `wl_rd_addr` = addr every cycle.
  - At addr == LEN[layer]-1: if layer == NUM_LAYERS-1 → READY. Otherwise layer+1, addr=0.
  - Otherwise addr+1.
- READY:
  - `weights_ready` = 1.
  - `pix_ready` = !cfg_start (combinational).
  - `cfg_start` → LOAD. It wins over a simultaneous `pix_valid`, which is not accepted.
  - Accept → WAIT with cur=0; register `layer_start[0]`=1; clear the watchdog.
- WAIT:
  - Only `layer_done[cur]` is sampled; done bits of other layers are ignored.
  - On done with cur < NUM_LAYERS-1: cur+1, `layer_start[cur+1]`=1, watchdog cleared.
  - On done with cur == NUM_LAYERS-1: `pix_done`=1, → READY.
  - Watchdog increments each WAIT cycle. At count == WDOG_CYCLES-1 without done: set `err_timeout`, abort to READY, no `pix_done`.
  - If done and timeout fall in the same cycle, done wins.
  - `cfg_start` is ignored in WAIT and LOAD.
- `err_timeout`: set has priority over `err_clear` in the same cycle. Pixel processing continues while the flag is set.
- Widths: addr and watchdog counters are unsigned; the watchdog is ⌈log2(WDOG_CYCLES)⌉ bits and saturates in no path.

## Timing
- Reset: state IDLE; layer, addr, and watchdog = 0. Every output = 0, including `wl_wr_*` and `err_timeout`. `rst_n` mid-LOAD or mid-WAIT aborts immediately; no partial pulses after release.
- Load: `cfg_start` sampled at edge E0. `wl_rd_en` is high for cycles 1..ΣLEN (3777 with defaults). `wl_wr_en` is high for cycles 2..ΣLEN+1. `weights_ready` rises in cycle ΣLEN+1.
- No gap cycles occur between layers during load; the layer switch is seamless.
- Per pixel:
  - `layer_start[0]` is high in the cycle after acceptance.
  - `layer_start[i+1]` is high in the cycle after `layer_done[i]` is sampled.
  - `pix_done` and `pix_ready` rise together in the cycle after the final done.
  - Overhead is 1 cycle per layer.
- `layer_start`, `pix_done`, `wl_*`, and `err_timeout` are registered outputs. `pix_ready`, `weights_ready`, and `busy` are decoded from state.

## Test plan
- Reset, then `cfg_start` with defaults:
  - `wl_rd_addr` runs 0..335, 0..980, 0..737 ×3, 0..245 with `wl_wr_en` one-hot layers 0..5 lagging one cycle.
  - `weights_ready` rises in cycle 3778.
- One pixel, each layer's done returned 3 cycles after its start: `layer_start` one-hot 0..5 in order, `pix_done` exactly once, total 24 cycles from acceptance to `pix_done`.
- `layer_done[2]` held during layer 1's wait: ignored. Layer 2 does not start until `layer_done[1]`.
- Withhold `layer_done[3]`:
  - `err_timeout` sets 4096 cycles after `layer_start[3]`.
  - Returns to READY with no `pix_done`.
  - `err_timeout` stays set until `err_clear`; a set and a clear in the same cycle leave it set.
- `cfg_start` and `pix_valid` together in READY: no accept, reload starts, `weights_ready` drops next cycle.
- `rst_n` asserted mid-WAIT (layer 4): all outputs 0 asynchronously; after release the block sits in IDLE and requires `cfg_start`.

Source files
------------

// File: rtl/sr_layer_sequencer.sv
// Central controller for the super-resolution core: streams every layer's weight
// memory through the shared loader, then runs each pixel through the layer chain.
module sr_layer_sequencer #(
    parameter int unsigned                    NUM_LAYERS  = 6,
    parameter int unsigned                    ADDR_WIDTH  = 18,
    parameter int unsigned                    LEN_W       = 11,
    parameter logic [NUM_LAYERS*LEN_W-1:0]    LAYER_LEN   = {11'd246, 11'd738, 11'd738,
                                                             11'd738, 11'd981, 11'd336},
    parameter int unsigned                    WDOG_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    output logic                    wl_rd_en,
    output logic [ADDR_WIDTH-1:0]   wl_rd_addr,
    output logic [NUM_LAYERS-1:0]   wl_wr_en,
    output logic [ADDR_WIDTH-1:0]   wl_wr_addr,
    output logic                    weights_ready,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic [NUM_LAYERS-1:0]   layer_start,
    input  logic [NUM_LAYERS-1:0]   layer_done,
    output logic                    pix_done,
    output logic                    busy,
    output logic                    err_timeout,
    input  logic                    err_clear
);

    localparam int unsigned LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned WDOG_W  = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]            state_q,   state_d;
    logic [LAYER_W-1:0]    layer_q,   layer_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [WDOG_W-1:0]     wdog_q,    wdog_d;
    logic                  rd_en_q,   rd_en_d;
    logic [NUM_LAYERS-1:0] wr_en_q,   wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [NUM_LAYERS-1:0] start_q,   start_d;
    logic                  pix_done_q, pix_done_d;
    logic                  err_q,     err_d;

    logic [LEN_W-1:0]      len_cur;
    logic [NUM_LAYERS-1:0] layer_sel;
    logic                  addr_last;
    logic                  layer_last;
    logic                  wdog_last;
    logic                  done_cur;
    logic                  accept;
    logic                  err_set;

    // Layer index doubles as the load layer in LOAD and the active layer in WAIT.
    assign len_cur    = LAYER_LEN[32'(layer_q) * LEN_W +: LEN_W];
    assign layer_sel  = NUM_LAYERS'(1) << layer_q;
    assign addr_last  = (addr_q == ADDR_WIDTH'(len_cur - LEN_W'(1)));
    assign layer_last = (layer_q == LAYER_W'(NUM_LAYERS - 1));
    assign wdog_last  = (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
    assign done_cur   = |(layer_done & layer_sel);

    assign weights_ready = (state_q == S_READY);
    assign pix_ready     = (state_q == S_READY) && !cfg_start;
    assign busy          = (state_q == S_LOAD) || (state_q == S_WAIT);
    assign accept        = pix_valid && pix_ready;

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        addr_d     = addr_q;
        wdog_d     = wdog_q;
        start_d    = '0;
        pix_done_d = 1'b0;
        err_set    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d = S_LOAD;
                    layer_d = '0;
                    addr_d  = '0;
                end
            end
            S_LOAD: begin
                if (addr_last) begin
                    addr_d = '0;
                    if (layer_last) begin
                        state_d = S_READY;
                        layer_d = '0;
                    end else begin
                        layer_d = layer_q + LAYER_W'(1);
                    end
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_READY: begin
                if (cfg_start) begin
                    state_d = S_LOAD;
                    layer_d = '0;
                    addr_d  = '0;
                end else if (accept) begin
                    state_d = S_WAIT;
                    layer_d = '0;
                    wdog_d  = '0;
                    start_d = NUM_LAYERS'(1);
                end
            end
            S_WAIT: begin
                // A done arriving on the watchdog's last cycle still counts.
                if (done_cur) begin
                    wdog_d = '0;
                    if (layer_last) begin
                        state_d    = S_READY;
                        layer_d    = '0;
                        pix_done_d = 1'b1;
                    end else begin
                        layer_d = layer_q + LAYER_W'(1);
                        start_d = layer_sel << 1;
                    end
                end else if (wdog_last) begin
                    state_d = S_READY;
                    layer_d = '0;
                    wdog_d  = '0;
                    err_set = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        rd_en_d   = (state_d == S_LOAD);
        wr_en_d   = rd_en_q ? layer_sel : '0;
        wr_addr_d = addr_q;
        err_d     = err_set ? 1'b1 : (err_clear ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            layer_q    <= '0;
            addr_q     <= '0;
            wdog_q     <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            start_q    <= '0;
            pix_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            addr_q     <= addr_d;
            wdog_q     <= wdog_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            start_q    <= start_d;
            pix_done_q <= pix_done_d;
            err_q      <= err_d;
        end
    end

    assign wl_rd_en    = rd_en_q;
    assign wl_rd_addr  = addr_q;
    assign wl_wr_en    = wr_en_q;
    assign wl_wr_addr  = wr_addr_q;
    assign layer_start = start_q;
    assign pix_done    = pix_done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_sr_layer_sequencer.sv
// Self-checking bench for sr_layer_sequencer: weight load, pixel sequencing,
// watchdog/error flag and asynchronous reset behaviour with default parameters.
module tb_sr_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_start = 1'b0;
    logic        wl_rd_en;
    logic [17:0] wl_rd_addr;
    logic [5:0]  wl_wr_en;
    logic [17:0] wl_wr_addr;
    logic        weights_ready;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [5:0]  layer_start;
    logic [5:0]  layer_done;
    logic        pix_done;
    logic        busy;
    logic        err_timeout;
    logic        err_clear = 1'b0;

    logic [5:0]  tb_done = '0;
    logic [5:0]  resp_done = '0;
    logic        resp_en = 1'b0;
    int          withhold = -1;
    int          resp_cnt = 0;
    int          resp_idx = 0;

    int n_tests = 0;
    int n_fail  = 0;

    int len_tab[6] = '{336, 981, 738, 738, 738, 246};

    int st_cyc[6];
    int st_order[$];
    int pd_cyc, pd_cnt, err_cyc, bad_onehot;
    logic pr_at_pd, prev_err;

    logic [53:0] outs;
    assign outs = {wl_rd_en, wl_rd_addr, wl_wr_en, wl_wr_addr, weights_ready,
                   pix_ready, layer_start, pix_done, busy, err_timeout};

    assign layer_done = tb_done | resp_done;

    always #5 clk = ~clk;

    sr_layer_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .wl_rd_en(wl_rd_en), .wl_rd_addr(wl_rd_addr),
        .wl_wr_en(wl_wr_en), .wl_wr_addr(wl_wr_addr),
        .weights_ready(weights_ready), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .layer_start(layer_start), .layer_done(layer_done), .pix_done(pix_done),
        .busy(busy), .err_timeout(err_timeout), .err_clear(err_clear)
    );

    // Downstream model: returns layer_done 3 cycles after each layer_start.
    always @(negedge clk) begin
        resp_done = '0;
        if (!resp_en) begin
            resp_cnt = 0;
        end else begin
            if (resp_cnt != 0) begin
                resp_cnt--;
                if (resp_cnt == 0 && resp_idx != withhold) resp_done[resp_idx] = 1'b1;
            end
            for (int i = 0; i < 6; i++)
                if (layer_start[i]) begin
                    resp_idx = i;
                    resp_cnt = 3;
                end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One pixel request served by the responder; records what the DUT emits.
    task automatic run_pixel(input int wh, input int ncyc, input int clr_at);
        withhold = wh;
        resp_en  = 1'b1;
        @(negedge clk);
        pix_valid = 1'b1;
        #1 check("accept_pix_ready", pix_ready, 1);
        for (int i = 0; i < 6; i++) st_cyc[i] = -1;
        st_order.delete();
        pd_cyc = -1; pd_cnt = 0; err_cyc = -1; bad_onehot = 0;
        pr_at_pd = 1'b0; prev_err = err_timeout;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            pix_valid = 1'b0;
            err_clear = (n == clr_at);
            if (layer_start != '0) begin
                if (!$onehot(layer_start)) bad_onehot++;
                for (int i = 0; i < 6; i++)
                    if (layer_start[i]) begin
                        st_cyc[i] = n;
                        st_order.push_back(i);
                    end
            end
            if (pix_done) begin
                pd_cnt++;
                if (pd_cyc < 0) begin
                    pd_cyc   = n;
                    pr_at_pd = pix_ready;
                end
            end
            if (err_timeout && !prev_err && err_cyc < 0) err_cyc = n;
            prev_err = err_timeout;
        end
        err_clear = 1'b0;
        resp_en   = 1'b0;
        withhold  = -1;
    endtask

    typedef struct {
        logic       cfg;
        logic       pv;
        logic [5:0] done;
        logic [5:0] e_start;
        logic       e_pd;
        logic       e_pr;
        logic       e_wr;
        logic       e_busy;
        logic       e_rd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int   k, load_bad, prev_l, prev_a, found;
        logic [5:0] one;
        logic [5:0] exp_wr;

        // Per-cycle vectors from READY: inputs for the cycle, expected outputs in it.
        vecs[0]  = '{1'b0, 1'b1, 6'b000000, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 6'b000001, 6'b000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 6'b000100, 6'b000010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 6'b000010, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 6'b000100, 6'b000100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 6'b001000, 6'b001000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 6'b010000, 6'b010000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 6'b100000, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 6'b000000, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset and idle.
        #3 rst_n = 1'b0;
        @(negedge clk);
        check("reset_outputs", outs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", outs, 0);

        // Full weight load.
        cfg_start = 1'b1;
        one = 6'd1;
        prev_l = -1; prev_a = 0; k = 0; load_bad = 0;
        for (int l = 0; l < 6; l++)
            for (int a = 0; a < len_tab[l]; a++) begin
                @(negedge clk);
                cfg_start = 1'b0;
                k++;
                exp_wr = (prev_l < 0) ? 6'd0 : (one << prev_l);
                if (wl_rd_en !== 1'b1 || wl_rd_addr !== 18'(a) || wl_wr_en !== exp_wr ||
                    wl_wr_addr !== 18'((prev_l < 0) ? 0 : prev_a) ||
                    weights_ready !== 1'b0 || busy !== 1'b1)
                    load_bad++;
                prev_l = l;
                prev_a = a;
            end
        check("load_cycle_count", k, 3777);
        check("load_mismatch_cycles", load_bad, 0);
        @(negedge clk);
        check("load_end_rd_en", wl_rd_en, 0);
        check("load_end_wr_en", wl_wr_en, 6'b100000);
        check("load_end_wr_addr", wl_wr_addr, 245);
        check("weights_ready_cycle_3778", weights_ready, 1);
        check("load_end_busy", busy, 0);
        @(negedge clk);
        check("load_tail_wr_en", wl_wr_en, 0);

        // One pixel, done returned 3 cycles after each start.
        run_pixel(-1, 30, 0);
        check("pix1_start_count", st_order.size(), 6);
        check("pix1_onehot", bad_onehot, 0);
        for (int i = 0; i < 6; i++) begin
            if (i < st_order.size()) check($sformatf("pix1_order%0d", i), st_order[i], i);
            check($sformatf("pix1_start%0d_cycle", i), st_cyc[i], 1 + 4 * i);
        end
        check("pix1_pix_done_count", pd_cnt, 1);
        check("pix1_latency", pd_cyc - 1, 24);
        check("pix1_ready_with_done", pr_at_pd, 1);

        // Table: immediate dones, stray done ignored, cfg_start beats pix_valid.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cfg_start = vecs[i].cfg;
            pix_valid = vecs[i].pv;
            tb_done   = vecs[i].done;
            #1;
            check($sformatf("vec%0d_layer_start", i), layer_start, vecs[i].e_start);
            check($sformatf("vec%0d_pix_done", i), pix_done, vecs[i].e_pd);
            check($sformatf("vec%0d_pix_ready", i), pix_ready, vecs[i].e_pr);
            check($sformatf("vec%0d_weights_ready", i), weights_ready, vecs[i].e_wr);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d_wl_rd_en", i), wl_rd_en, vecs[i].e_rd);
        end
        cfg_start = 1'b0; pix_valid = 1'b0; tb_done = '0;

        // Let the reload finish.
        found = 0;
        for (int n = 0; n < 4000 && found == 0; n++) begin
            @(negedge clk);
            if (weights_ready) found = 1;
        end
        check("reload_completes", found, 1);

        // Layer 3 never answers: watchdog abort.
        run_pixel(3, 4115, 0);
        check("wdog_start3_seen", st_cyc[3], 13);
        check("wdog_err_delay", err_cyc - st_cyc[3], 4096);
        check("wdog_no_pix_done", pd_cnt, 0);
        check("wdog_no_layer4", st_cyc[4], -1);
        check("wdog_back_ready", pix_ready, 1);
        check("err_sticky", err_timeout, 1);

        // Processing continues with the flag set.
        run_pixel(-1, 30, 0);
        check("pix2_pix_done_count", pd_cnt, 1);
        check("pix2_latency", pd_cyc - 1, 24);
        check("pix2_err_still_set", err_timeout, 1);

        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("err_cleared", err_timeout, 0);

        // Timeout coincides with err_clear: set wins.
        run_pixel(3, 4115, 4108);
        check("set_beats_clear_cycle", err_cyc - st_cyc[3], 4096);
        check("set_beats_clear", err_timeout, 1);

        // Asynchronous reset while waiting on layer 4.
        resp_en = 1'b1;
        @(negedge clk);
        pix_valid = 1'b1;
        found = 0;
        for (int n = 1; n <= 40 && found == 0; n++) begin
            @(negedge clk);
            pix_valid = 1'b0;
            if (layer_start[4]) found = 1;
        end
        check("reach_layer4", found, 1);
        @(negedge clk);
        resp_en = 1'b0;
        check("busy_before_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", outs, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            #1 check($sformatf("post_reset_idle%0d", n), outs, 0);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("post_reset_load_busy", busy, 1);
        check("post_reset_load_rd_en", wl_rd_en, 1);
        check("post_reset_load_addr", wl_rd_addr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
